t05_cpu_sequencer: RTL and testbench

- Multi-cycle sequencer for the team_05 RV32I core.
- Fetches instruction words over a request/ack memory port and holds them in an instruction register (IR) that drives the instruction decoder.
- Runs each instruction through decode/execute/memory/writeback, owns the PC and issues register-file write strobes.
- A memory watchdog halts the core if the memory port never acks.

---
 rtl/t05_cpu_sequencer_pkg.sv | 38 +++
 rtl/t05_cpu_sequencer_if.sv | 16 +
 rtl/t05_cpu_sequencer_watchdog.sv | 28 ++
 rtl/t05_cpu_sequencer.sv | 145 ++++++++++++++
 tb/tb_t05_cpu_sequencer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/t05_cpu_sequencer_pkg.sv
// t05_cpu_pkg: shared types and constants for the team_05 multi-cycle sequencer.
//   state_t         - FSM state encoding (also exported on the debug port)
//   OP_*            - RV32I major opcodes the sequencer distinguishes
//   PC_STEP         - sequential PC increment
//   op_writes_rd()  - opcode produces a register-file write
//   op_known()      - opcode is handled by this core
package t05_cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic op_writes_rd(input logic [6:0] op);
    return (op == OP_R) || (op == OP_IMM) || (op == OP_LOAD) ||
           (op == OP_JALR) || (op == OP_JAL) || (op == OP_LUI);
  endfunction

  function automatic logic op_known(input logic [6:0] op);
    return op_writes_rd(op) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/t05_cpu_sequencer_if.sv
// t05_cpu_sequencer_if: request/ack memory port of the sequencer.
//   mem_read/mem_write - request strobes, held until mem_ack
//   mem_addr           - request address
//   mem_ack            - transaction complete; mem_rdata valid this cycle
//   mem_rdata          - read data
// master = sequencer side, slave = memory side.
interface t05_cpu_sequencer_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_read, mem_write, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_read, mem_write, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/t05_cpu_sequencer_watchdog.sv
// t05_mem_watchdog: counts cycles a memory request waits for ack.
//   clk, nRst - clock, asynchronous active-low reset
//   clear     - zero the count (no request, or ack this cycle)
//   count_en  - request high without ack this cycle
//   expired   - this wait cycle is the MEM_TIMEOUT-th one without ack
module t05_mem_watchdog #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic nRst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [15:0] r_count;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst)         r_count <= '0;
    else if (clear)    r_count <= '0;
    else if (count_en) r_count <= r_count + 16'd1;
  end

  // r_count holds the number of earlier wait cycles, so the MEM_TIMEOUT-th
  // wait cycle is the one that sees MEM_TIMEOUT-1.
  assign expired = count_en && (r_count == 16'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/t05_cpu_sequencer.sv
// t05_cpu_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer.
//   clk, nRst        - clock, asynchronous active-low reset
//   en               - run enable, sampled in FETCH before a request is issued
//   mem_bus          - request/ack memory port (master)
//   opcode           - decoded opcode of IR
//   alu_result       - load/store address
//   branch_taken     - branch condition
//   jump_target      - branch/JAL/JALR target
//   instruction, pc  - IR and PC
//   load_data        - registered load result
//   reg_write        - register-file write strobe (WRITEBACK)
//   illegal_op       - unknown opcode pulse (WRITEBACK)
//   mem_fault        - sticky watchdog fault
//   state            - FSM state for debug
module t05_cpu_sequencer
  import t05_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        nRst,
  input  logic                        en,
  t05_cpu_sequencer_if.master         mem_bus,
  input  logic [6:0]                  opcode,
  input  logic [31:0]                 alu_result,
  input  logic                        branch_taken,
  input  logic [31:0]                 jump_target,
  output logic [31:0]                 instruction,
  output logic [31:0]                 pc,
  output logic [31:0]                 load_data,
  output logic                        reg_write,
  output logic                        illegal_op,
  output logic                        mem_fault,
  output logic [2:0]                  state
);

  state_t      r_state, w_next_state;
  logic [31:0] r_pc, r_ir, r_load_data;
  logic        r_fetch_busy, r_fault;
  logic        w_mem_read, w_mem_write, w_req, w_ack, w_expired;
  logic        w_reg_write, w_illegal, w_take_jump;
  logic [31:0] w_mem_addr;

  assign w_ack       = mem_bus.mem_ack;
  assign w_req       = w_mem_read || w_mem_write;
  assign w_take_jump = (opcode == OP_JAL) || (opcode == OP_JALR) ||
                       ((opcode == OP_BRANCH) && branch_taken);

  t05_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_watchdog (
    .clk      (clk),
    .nRst     (nRst),
    .clear    (!w_req || w_ack),
    .count_en (w_req && !w_ack),
    .expired  (w_expired)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) r_state <= ST_FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FETCH: begin
        if (w_req) begin
          if (w_ack)          w_next_state = ST_DECODE;
          else if (w_expired) w_next_state = ST_HALT;
        end
      end
      ST_DECODE:  w_next_state = ST_EXECUTE;
      ST_EXECUTE: w_next_state = ((opcode == OP_LOAD) || (opcode == OP_STORE)) ? ST_MEM
                                                                               : ST_WRITEBACK;
      ST_MEM: begin
        if (!w_req || w_ack) w_next_state = ST_WRITEBACK;
        else if (w_expired)  w_next_state = ST_HALT;
      end
      ST_WRITEBACK: w_next_state = ST_FETCH;
      ST_HALT:      w_next_state = ST_HALT;
      default:      w_next_state = ST_HALT;
    endcase
  end

  always_comb begin
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_mem_addr  = r_pc;
    w_reg_write = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      // Once a fetch request is out, r_fetch_busy keeps it up even if en drops.
      ST_FETCH: w_mem_read = en || r_fetch_busy;
      ST_MEM: begin
        w_mem_addr  = alu_result;
        w_mem_read  = (opcode == OP_LOAD);
        w_mem_write = (opcode == OP_STORE);
      end
      ST_WRITEBACK: begin
        w_reg_write = op_writes_rd(opcode);
        w_illegal   = !op_known(opcode);
      end
      default: ;
    endcase
    // Strobes fall with reset itself, not at the next edge.
    if (!nRst) begin
      w_mem_read  = 1'b0;
      w_mem_write = 1'b0;
      w_reg_write = 1'b0;
      w_illegal   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_pc         <= RESET_PC;
      r_ir         <= '0;
      r_load_data  <= '0;
      r_fetch_busy <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_fetch_busy <= (r_state == ST_FETCH) && w_req && !w_ack && !w_expired;
      if ((r_state == ST_FETCH) && w_req && w_ack)
        r_ir <= mem_bus.mem_rdata;
      if ((r_state == ST_MEM) && w_mem_read && w_ack)
        r_load_data <= mem_bus.mem_rdata;
      if (r_state == ST_WRITEBACK)
        r_pc <= w_take_jump ? {jump_target[31:2], 2'b00} : r_pc + PC_STEP;
      if (w_req && !w_ack && w_expired)
        r_fault <= 1'b1;
    end
  end

  assign mem_bus.mem_read  = w_mem_read;
  assign mem_bus.mem_write = w_mem_write;
  assign mem_bus.mem_addr  = w_mem_addr;
  assign instruction       = r_ir;
  assign pc                = r_pc;
  assign load_data         = r_load_data;
  assign reg_write         = w_reg_write;
  assign illegal_op        = w_illegal;
  assign mem_fault         = r_fault;
  assign state             = r_state;

endmodule

// File: tb/tb_t05_cpu_sequencer.sv
module tb_t05_cpu_sequencer;

  logic        clk = 1'b0;
  logic        nRst, en, branch_taken;
  logic [31:0] alu_result, jump_target;
  logic [6:0]  opcode;
  logic [31:0] instruction, pc, load_data;
  logic        reg_write, illegal_op, mem_fault;
  logic [2:0]  state;
  int          errors = 0;
  int          checks = 0;

  t05_cpu_sequencer_if mem_bus();

  // Stand-in decoder: opcode field of IR.
  assign opcode = instruction[6:0];

  always #5 clk = ~clk;

  t05_cpu_sequencer #(.RESET_PC(32'h0000_0000), .MEM_TIMEOUT(8)) dut (
    .clk          (clk),
    .nRst         (nRst),
    .en           (en),
    .mem_bus      (mem_bus),
    .opcode       (opcode),
    .alu_result   (alu_result),
    .branch_taken (branch_taken),
    .jump_target  (jump_target),
    .instruction  (instruction),
    .pc           (pc),
    .load_data    (load_data),
    .reg_write    (reg_write),
    .illegal_op   (illegal_op),
    .mem_fault    (mem_fault),
    .state        (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    nRst = 1'b0; en = 1'b0; branch_taken = 1'b0;
    alu_result = '0; jump_target = '0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
    #2;
    chk("rst_pc", pc, 32'h0);
    chk("rst_state", state, 0);
    chk("rst_ir", instruction, 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_mem_read", mem_bus.mem_read, 0);
    chk("rst_mem_write", mem_bus.mem_write, 0);
    chk("rst_reg_write", reg_write, 0);
    chk("rst_illegal", illegal_op, 0);
    chk("rst_fault", mem_fault, 0);

    // en=0: no request
    @(negedge clk); nRst = 1'b1; #1;
    chk("idle_rd", mem_bus.mem_read, 0);
    @(negedge clk); #1;
    chk("idle_state", state, 0);
    chk("idle_rd2", mem_bus.mem_read, 0);

    // addi with same-cycle ack: 0,1,2,4,0
    @(negedge clk); en = 1'b1; mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h00A00093; #1;
    chk("addi_fetch_rd", mem_bus.mem_read, 1);
    chk("addi_fetch_addr", mem_bus.mem_addr, 32'h0);
    @(negedge clk); mem_bus.mem_ack = 1'b0; #1;
    chk("addi_decode", state, 1);
    chk("addi_ir", instruction, 32'h00A00093);
    chk("addi_decode_rd", mem_bus.mem_read, 0);
    @(negedge clk); #1;
    chk("addi_execute", state, 2);
    @(negedge clk); #1;
    chk("addi_wb", state, 4);
    chk("addi_reg_write", reg_write, 1);
    chk("addi_illegal", illegal_op, 0);
    @(negedge clk); #1;
    chk("addi_back_fetch", state, 0);
    chk("addi_pc", pc, 32'h4);
    chk("addi_reg_write_off", reg_write, 0);

    // load with data ack after 3 wait cycles
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h0000A103; #1;
    chk("ld_fetch_addr", mem_bus.mem_addr, 32'h4);
    @(negedge clk); mem_bus.mem_ack = 1'b0; #1;
    chk("ld_decode", state, 1);
    @(negedge clk); alu_result = 32'h100; #1;
    chk("ld_execute", state, 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("ld_wait_state", state, 3);
      chk("ld_wait_rd", mem_bus.mem_read, 1);
      chk("ld_wait_wr", mem_bus.mem_write, 0);
      chk("ld_wait_addr", mem_bus.mem_addr, 32'h100);
    end
    @(negedge clk); mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hDEADBEEF; #1;
    chk("ld_ack_rd", mem_bus.mem_read, 1);
    @(negedge clk); mem_bus.mem_ack = 1'b0; #1;
    chk("ld_wb", state, 4);
    chk("ld_data", load_data, 32'hDEADBEEF);
    chk("ld_reg_write", reg_write, 1);
    @(negedge clk); #1;
    chk("ld_pc", pc, 32'h8);

    // taken branch to 0x47 -> 0x44
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h00000063; #1;
    chk("br_fetch_addr", mem_bus.mem_addr, 32'h8);
    @(negedge clk); mem_bus.mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk); branch_taken = 1'b1; jump_target = 32'h47; #1;
    chk("br_wb", state, 4);
    chk("br_reg_write", reg_write, 0);
    @(negedge clk); branch_taken = 1'b0; #1;
    chk("br_pc", pc, 32'h44);

    // store with same-cycle ack
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h0020A023; #1;
    chk("st_fetch_addr", mem_bus.mem_addr, 32'h44);
    @(negedge clk); mem_bus.mem_ack = 1'b0;
    @(negedge clk); alu_result = 32'h200;
    @(negedge clk); mem_bus.mem_ack = 1'b1; #1;
    chk("st_mem_state", state, 3);
    chk("st_mem_write", mem_bus.mem_write, 1);
    chk("st_mem_read", mem_bus.mem_read, 0);
    chk("st_mem_addr", mem_bus.mem_addr, 32'h200);
    @(negedge clk); mem_bus.mem_ack = 1'b0; #1;
    chk("st_wb", state, 4);
    chk("st_reg_write", reg_write, 0);
    chk("st_load_data_kept", load_data, 32'hDEADBEEF);
    @(negedge clk); #1;
    chk("st_pc", pc, 32'h48);

    // JAL to 0xFFFFFFFF -> 0xFFFFFFFC
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h0000006F;
    @(negedge clk); mem_bus.mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk); jump_target = 32'hFFFF_FFFF; #1;
    chk("jal_reg_write", reg_write, 1);
    @(negedge clk); #1;
    chk("jal_pc", pc, 32'hFFFF_FFFC);

    // pc wraps to 0
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h00A00093; #1;
    chk("wrap_fetch_addr", mem_bus.mem_addr, 32'hFFFF_FFFC);
    @(negedge clk); mem_bus.mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("wrap_wb", state, 4);
    @(negedge clk); #1;
    chk("wrap_pc", pc, 32'h0);

    // unknown opcode
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h0000007F;
    @(negedge clk); mem_bus.mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("ill_wb", state, 4);
    chk("ill_pulse", illegal_op, 1);
    chk("ill_reg_write", reg_write, 0);
    @(negedge clk); #1;
    chk("ill_pulse_end", illegal_op, 0);
    chk("ill_pc", pc, 32'h4);

    // en dropped mid-fetch: request held
    chk("hold_rd1", mem_bus.mem_read, 1);
    @(negedge clk); en = 1'b0; #1;
    chk("hold_rd2", mem_bus.mem_read, 1);
    @(negedge clk); mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h00A00093; #1;
    chk("hold_rd3", mem_bus.mem_read, 1);
    @(negedge clk); mem_bus.mem_ack = 1'b0; #1;
    chk("hold_decode", state, 1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); #1;
    chk("hold_idle_state", state, 0);
    chk("hold_idle_rd", mem_bus.mem_read, 0);
    chk("hold_pc", pc, 32'h8);

    // ack on the 8th wait cycle wins over expiry
    en = 1'b1; #1;
    chk("late_rd_c1", mem_bus.mem_read, 1);
    for (int i = 2; i <= 7; i++) begin
      @(negedge clk); #1;
      chk("late_rd", mem_bus.mem_read, 1);
    end
    @(negedge clk); mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h00A00093; #1;
    chk("late_rd_c8", mem_bus.mem_read, 1);
    @(negedge clk); mem_bus.mem_ack = 1'b0; #1;
    chk("late_decode", state, 1);
    chk("late_no_fault", mem_fault, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); #1;
    chk("late_pc", pc, 32'hC);

    // reset asserted mid-MEM
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h0000A103;
    @(negedge clk); mem_bus.mem_ack = 1'b0;
    @(negedge clk); alu_result = 32'h100;
    @(negedge clk); #1;
    chk("rmid_state", state, 3);
    chk("rmid_rd", mem_bus.mem_read, 1);
    #1; nRst = 1'b0; #1;
    chk("rmid_rd_drop", mem_bus.mem_read, 0);
    chk("rmid_wr", mem_bus.mem_write, 0);
    chk("rmid_pc", pc, 32'h0);
    chk("rmid_state_fetch", state, 0);
    chk("rmid_ir", instruction, 32'h0);
    chk("rmid_load_data", load_data, 32'h0);

    // no ack: 8 wait cycles then HALT with fault
    @(negedge clk); nRst = 1'b1; #1;
    chk("to_rd_c1", mem_bus.mem_read, 1);
    for (int i = 2; i <= 8; i++) begin
      @(negedge clk); #1;
      chk("to_rd", mem_bus.mem_read, 1);
      chk("to_no_fault_yet", mem_fault, 0);
    end
    @(negedge clk); #1;
    chk("to_halt", state, 5);
    chk("to_rd_drop", mem_bus.mem_read, 0);
    chk("to_fault", mem_fault, 1);
    @(negedge clk); mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h12345678; #1;
    chk("halt_rd", mem_bus.mem_read, 0);
    @(negedge clk); mem_bus.mem_ack = 1'b0; #1;
    chk("halt_state", state, 5);
    chk("halt_pc", pc, 32'h0);
    chk("halt_ir", instruction, 32'h0);
    chk("halt_fault_sticky", mem_fault, 1);
    chk("halt_reg_write", reg_write, 0);
    nRst = 1'b0; #1;
    chk("halt_reset_fault", mem_fault, 0);
    chk("halt_reset_state", state, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
